// File: rtl/mmio_io_ctrl.sv
// rtl/mmio_io_ctrl.sv - memory-mapped I/O controller: decode, LED/HEX registers, debounced keys with W1C edge latch
module mmio_io_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LED_W           = 10,
    parameter int HEX_W           = 24,
    parameter int KEY_W           = 4,
    parameter int SW_W            = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    input  logic              memwrite,
    output logic [31:0]       readdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [KEY_W-1:0]  key_in,
    input  logic [SW_W-1:0]   sw_in,
    output logic [LED_W-1:0]  ledr,
    output logic [HEX_W-1:0]  hex_digits,
    output logic              key_irq
);

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic is_io;
    logic sel_led;
    logic sel_hex;
    logic sel_key;
    logic sel_sw;
    logic sel_kedge;
    logic io_wr;

    logic [KEY_W-1:0] sync1;
    logic [KEY_W-1:0] sync2;
    logic [KEY_W-1:0] pressed;
    logic [KEY_W-1:0] key_state;
    logic [KEY_W-1:0] key_edge;
    logic [KEY_W-1:0] rise;
    logic [KEY_W-1:0] clr;
    logic [15:0]      cnt [KEY_W];

    // Address bits outside the decoded set are deliberately don't-care.
    logic unused_bits;
    assign unused_bits = &{1'b0, addr[31:9], addr[7], addr[1:0], writedata};

    assign is_io     = addr[8];
    assign sel_led   = addr[2];
    assign sel_hex   = addr[3];
    assign sel_key   = addr[4];
    assign sel_sw    = addr[5];
    assign sel_kedge = addr[6];
    assign io_wr     = memwrite & is_io;

    // RAM can only be written outside the I/O window
    assign ram_we = memwrite & ~is_io;

    // Output registers; several select bits at once write several registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            ledr       <= '0;
            hex_digits <= '0;
        end else begin
            if (io_wr && sel_led) ledr       <= writedata[LED_W-1:0];
            if (io_wr && sel_hex) hex_digits <= writedata[HEX_W-1:0];
        end
    end

    // Two-flop synchronizer for the asynchronous buttons, idling at released
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    // A press/release is taken once the sample has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        rise = '0;
        for (int i = 0; i < KEY_W; i++) begin
            rise[i] = pressed[i] & ~key_state[i] & (cnt[i] == CNT_MAX);
        end
    end

    // Per-key debounce counter and accepted state
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_state <= '0;
            for (int i = 0; i < KEY_W; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < KEY_W; i++) begin
                if (pressed[i] == key_state[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    key_state[i] <= pressed[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    assign clr = (io_wr && sel_kedge) ? writedata[KEY_W-1:0] : '0;

    // Sticky press events; a new press beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_edge <= '0;
        end else begin
            key_edge <= (key_edge & ~clr) | rise;
        end
    end

    assign key_irq = |key_edge;

    // Zero-latency read mux, lowest select bit has priority
    always_comb begin
        readdata = 32'h0;
        if (!is_io)         readdata = ram_rdata;
        else if (sel_led)   readdata = 32'(ledr);
        else if (sel_hex)   readdata = 32'(hex_digits);
        else if (sel_key)   readdata = 32'(key_state);
        else if (sel_sw)    readdata = 32'(sw_in);
        else if (sel_kedge) readdata = 32'(key_edge);
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb/tb_mmio_io_ctrl.sv - randomized self-checking bench for mmio_io_ctrl against a behavioural model
module tb_mmio_io_ctrl;

    localparam int DC  = 4;
    localparam int LW  = 10;
    localparam int HW  = 24;
    localparam int KW  = 4;
    localparam int SWW = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    addr;
    logic [31:0]    writedata;
    logic           memwrite;
    logic [31:0]    readdata;
    logic           ram_we;
    logic [31:0]    ram_rdata;
    logic [KW-1:0]  key_in;
    logic [SWW-1:0] sw_in;
    logic [LW-1:0]  ledr;
    logic [HW-1:0]  hex_digits;
    logic           key_irq;

    always #5 clk = ~clk;

    mmio_io_ctrl #(
        .DEBOUNCE_CYCLES(DC), .LED_W(LW), .HEX_W(HW), .KEY_W(KW), .SW_W(SWW)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .writedata(writedata),
        .memwrite(memwrite), .readdata(readdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .key_in(key_in), .sw_in(sw_in),
        .ledr(ledr), .hex_digits(hex_digits), .key_irq(key_irq)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [LW-1:0] m_led;
    logic [HW-1:0] m_hex;
    logic [KW-1:0] m_state;
    logic [KW-1:0] m_edge;
    logic [KW-1:0] m_d1;
    logic [KW-1:0] m_d2;
    logic [KW-1:0] s_hist[$];
    bit            m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read();
        if (!addr[8]) return ram_rdata;
        if (addr[2])  return 32'(m_led);
        if (addr[3])  return 32'(m_hex);
        if (addr[4])  return 32'(m_state);
        if (addr[5])  return 32'(sw_in);
        if (addr[6])  return 32'(m_edge);
        return 32'h0;
    endfunction

    task automatic compare_all();
        check("ledr",     32'(ledr),       32'(m_led));
        check("hex",      32'(hex_digits), 32'(m_hex));
        check("key_irq",  32'(key_irq),    32'(|m_edge));
        check("ram_we",   32'(ram_we),     32'(memwrite & ~addr[8]));
        check("readdata", readdata,        exp_read());
    endtask

    // Advance the model by one rising edge using the currently driven inputs
    task automatic model_edge();
        logic [KW-1:0] s;
        logic [KW-1:0] rise;
        logic [KW-1:0] nstate;
        logic [KW-1:0] clr;
        bit            all_diff;
        if (!reset) begin
            m_led = '0; m_hex = '0; m_state = '0; m_edge = '0;
            m_d1 = '1; m_d2 = '1;
            s_hist.delete();
            m_valid = 1'b1;
        end else begin
            s = ~m_d2;
            s_hist.push_back(s);
            if (s_hist.size() > DC) void'(s_hist.pop_front());
            rise   = '0;
            nstate = m_state;
            if (s_hist.size() == DC) begin
                for (int i = 0; i < KW; i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DC; j++) all_diff &= (s_hist[j][i] != m_state[i]);
                    if (all_diff) begin
                        nstate[i] = s[i];
                        rise[i]   = s[i];
                    end
                end
            end
            clr     = (memwrite && addr[8] && addr[6]) ? writedata[KW-1:0] : '0;
            m_edge  = (m_edge & ~clr) | rise;
            m_state = nstate;
            if (memwrite && addr[8] && addr[2]) m_led = writedata[LW-1:0];
            if (memwrite && addr[8] && addr[3]) m_hex = writedata[HW-1:0];
            m_d2 = m_d1;
            m_d1 = key_in;
        end
    endtask

    task automatic cycle(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                         input logic mw, input logic [KW-1:0] k, input logic [31:0] r);
        reset = rst; addr = a; writedata = wd; memwrite = mw; key_in = k; ram_rdata = r;
        #1;
        if (m_valid) compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [KW-1:0] k);
        for (int i = 0; i < n; i++) cycle(1'b1, 32'h0, 32'h0, 1'b0, k, 32'h0);
    endtask

    task automatic peek(input logic [31:0] a, input logic mw);
        addr = a; memwrite = mw;
        #1;
    endtask

    logic [KW-1:0] kval;
    int            khold [KW];
    logic [31:0]   ra;

    initial begin
        reset = 1'b0; addr = '0; writedata = '0; memwrite = 1'b0;
        key_in = '1; sw_in = '0; ram_rdata = '0;

        // Reset with a concurrent I/O write that must lose
        repeat (3) cycle(1'b0, 32'h104, 32'hFFFF_FFFF, 1'b1, '1, 32'h0);
        reset = 1'b1;
        peek(32'h110, 1'b0);
        check("rst_ledr", 32'(ledr), 32'h0);
        check("rst_hex",  32'(hex_digits), 32'h0);
        check("rst_irq",  32'(key_irq), 32'h0);
        check("rst_key",  readdata, 32'h0);
        peek(32'h140, 1'b0);
        check("rst_edge", readdata, 32'h0);

        // LED and multi-select writes
        peek(32'h104, 1'b1);
        check("io_ram_we", 32'(ram_we), 32'h0);
        cycle(1'b1, 32'h104, 32'h3FF, 1'b1, '1, 32'h0);
        check("led_wr", 32'(ledr), 32'h3FF);
        cycle(1'b1, 32'h10C, 32'h123456, 1'b1, '1, 32'h0);
        check("multi_led", 32'(ledr), 32'h056);
        check("multi_hex", 32'(hex_digits), 32'h123456);

        // RAM window write and reads
        peek(32'h40, 1'b1);
        check("ram_we", 32'(ram_we), 32'h1);
        cycle(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, '1, 32'hDEAD_BEEF);
        check("ram_led_keep", 32'(ledr), 32'h056);
        ram_rdata = 32'hDEAD_BEEF;
        peek(32'h40, 1'b0);
        check("ram_read", readdata, 32'hDEAD_BEEF);
        sw_in = 10'h2A5;
        peek(32'h120, 1'b0);
        check("sw_read", readdata, 32'h0000_02A5);

        // Key 2 press: accepted on the sixth sampling edge
        idle(5, 4'b1011);
        peek(32'h110, 1'b0);
        check("key_early", readdata, 32'h0);
        idle(1, 4'b1011);
        peek(32'h110, 1'b0);
        check("key_state", readdata, 32'h4);
        check("key_irq", 32'(key_irq), 32'h1);
        peek(32'h140, 1'b0);
        check("key_edge", readdata, 32'h4);
        idle(4, 4'b1011);
        idle(8, 4'b1111);
        peek(32'h140, 1'b0);
        check("rel_edge", readdata, 32'h4);

        // Short glitch on key 0
        idle(3, 4'b1110);
        idle(8, 4'b1111);
        peek(32'h110, 1'b0);
        check("glitch_state", readdata, 32'h0);
        peek(32'h140, 1'b0);
        check("glitch_edge", readdata, 32'h4);

        // Key 0 press, then W1C
        idle(8, 4'b1110);
        idle(8, 4'b1111);
        peek(32'h140, 1'b0);
        check("edge_5", readdata, 32'h5);
        cycle(1'b1, 32'h140, 32'h1, 1'b1, 4'b1111, 32'h0);
        peek(32'h140, 1'b0);
        check("w1c", readdata, 32'h4);
        check("w1c_irq", 32'(key_irq), 32'h1);

        // Clear and new press on the same edge: set wins
        idle(5, 4'b1011);
        cycle(1'b1, 32'h140, 32'h4, 1'b1, 4'b1011, 32'h0);
        peek(32'h140, 1'b0);
        check("set_wins", readdata, 32'h4);
        idle(4, 4'b1011);
        idle(8, 4'b1111);

        // Reset in the middle of a key 1 debounce
        idle(4, 4'b1101);
        cycle(1'b0, 32'h104, 32'h2AA, 1'b1, 4'b1101, 32'h0);
        peek(32'h110, 1'b0);
        check("mid_rst_led", 32'(ledr), 32'h0);
        check("mid_rst_key", readdata, 32'h0);
        idle(5, 4'b1101);
        peek(32'h110, 1'b0);
        check("post_rst_early", readdata, 32'h0);
        idle(1, 4'b1101);
        peek(32'h110, 1'b0);
        check("post_rst_key", readdata, 32'h2);
        idle(8, 4'b1111);

        // Randomized traffic
        kval = '1;
        for (int i = 0; i < KW; i++) khold[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < KW; i++) begin
                if (khold[i] == 0) begin
                    kval[i]  = 1'($urandom_range(0, 1));
                    khold[i] = $urandom_range(1, 9);
                end
                khold[i]--;
            end
            ra    = $urandom;
            ra[8] = ($urandom_range(0, 3) != 0);
            sw_in = SWW'($urandom);
            cycle(($urandom_range(0, 299) != 0), ra, $urandom,
                  1'($urandom_range(0, 1)), kval, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O controller between the riscvmulti core bus (addr/writedata/memwrite/readdata) and the RAM plus board peripherals.
- Decodes the I/O window and gates RAM writes.
- Holds the LED and HEX output registers.
- Synchronizes and debounces the push-buttons, and latches press events in a write-1-to-clear register.
- Multiplexes RAM or I/O data back to the core.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before a key state change is accepted (range 1..65535).
- LED_W, 10, LED register width.
- HEX_W, 24, HEX digit register width.
- KEY_W, 4, number of push-buttons.
- SW_W, 10, number of slide switches.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted), sampled on the rising edge of clk.
- addr  in  32  core byte address.
- writedata  in  32  core store data.
- memwrite  in  1  core write strobe.
- readdata  out  32  load data to the core.
- ram_we  out  1  write enable to the RAM.
- ram_rdata  in  32  RAM read data (asynchronous read).
- key_in  in  KEY_W  raw buttons, active-low (0 = pressed), asynchronous.
- sw_in  in  SW_W  raw switches, quasi-static.
- ledr  out  LED_W  LED register.
- hex_digits  out  HEX_W  HEX register.
- key_irq  out  1  high when any key edge bit is set.

Behaviour:
- Decode:
  - isIO = addr[8]; isRAM = !isIO.
  - Select bits within the I/O window: LEDS = addr[2] (0x104), HEX = addr[3] (0x108), KEY = addr[4] (0x110), SW = addr[5] (0x120), KEYEDGE = addr[6] (0x140).
  - addr[1:0] and all other address bits are ignored.
- ram_we = memwrite & isRAM, combinational. The RAM is never written while isIO = 1.
- I/O writes (memwrite & isIO, rising edge):
  - Every selected writable register updates, so multiple select bits write multiple registers.
  - LEDS: ledr <= writedata[LED_W-1:0].
  - HEX: hex_digits <= writedata[HEX_W-1:0].
  - KEYEDGE: write-1-to-clear; edge[i] cleared where writedata[i] = 1.
  - KEY and SW are read-only; writes to them are ignored.
- Reads (combinational, zero latency, valid in the same cycle as addr):
  - isRAM: readdata = ram_rdata.
  - isIO: the lowest set select bit wins, in order LEDS, HEX, KEY, SW, KEYEDGE.
  - Value is zero-extended to 32 bits.
  - KEY reads return key_state (1 = pressed).
  - isIO with no select bit set: readdata = 0.
  - Reads have no side effects.
- Key path, per key, all independent:
  - Two-flop synchronizer sync1 -> sync2. Both reset to 1 (released).
  - s = ~sync2, so 1 = pressed.
  - Counter cnt[15:0]:
    - If s == key_state: cnt <= 0.
    - Else if cnt == DEBOUNCE_CYCLES-1: key_state <= s and cnt <= 0.
    - Else: cnt <= cnt+1.
  - Latency: key_in first sampled low at edge N -> key_state = 1 after edge N+1+DEBOUNCE_CYCLES.
  - A synchronized glitch shorter than DEBOUNCE_CYCLES cycles causes no state change and no edge.
- Edge capture:
  - edge[i] <= 1 on the edge where key_state[i] goes 0 -> 1.
  - Releases set nothing.
  - Set and W1C clear in the same cycle: set wins (edge stays 1).
  - Bits stay sticky until cleared.
- key_irq = |edge, combinational from the register.
- Reset (reset == 0 at a rising edge):
  - ledr = 0, hex_digits = 0, key_state = 0, edge = 0, cnt = 0, sync1 = sync2 = all-ones.
  - key_irq = 0.
  - Reset overrides a concurrent I/O write.
  - A debounce in progress is discarded.
- Combinational outputs during reset:
  - ram_we follows its equation.
  - readdata follows its mux.

Test Plan:
- Reset 3 cycles, then release -> ledr=0, hex_digits=0, key_irq=0. A read of 0x110 returns 0x0; a read of 0x140 returns 0x0.
- memwrite, addr=0x104, writedata=0x3FF -> ledr=0x3FF next edge, ram_we=0. Write addr=0x10C, data=0x123456 -> ledr=0x056 and hex_digits=0x123456.
- memwrite, addr=0x40, data=0xDEADBEEF -> ram_we=1, ledr unchanged. Read addr=0x40 with ram_rdata=0xDEADBEEF -> readdata=0xDEADBEEF. Read 0x120 with sw_in=0x2A5 -> readdata=0x000002A5.
- DEBOUNCE_CYCLES=4; key_in[2] driven low, held 10 cycles, first sampled at edge N -> key_state=0x4 after edge N+5, edge=0x4, key_irq=1. A 3-cycle low pulse on key_in[0] -> no change.
- With edge=0x5: write 0x140 data=0x1 -> edge=0x4, key_irq=1. Write data=0x4 on the same edge that key 2 registers a new press -> edge bit 2 remains 1.
- Assert reset mid-debounce (cnt=2) while memwrite to 0x104 is active -> ledr=0, cnt=0, no key_state change. After release, the key must be stable for the full 4 cycles again.
